// File: rtl/dff_asynch.sv
// dff_asynch: WIDTH-bit storage register with synchronous active-high clear.
// OUTPUT is driven straight from the flop; INPUT and CLEAR only act when sampled
// on a rising CLOCK edge.
module dff_asynch #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic [WIDTH-1:0] INPUT,
   input  logic             CLOCK,
   input  logic             CLEAR,
   output logic [WIDTH-1:0] OUTPUT
);

   // Reject out-of-range widths at elaboration.
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("dff_asynch: WIDTH must be in 1..64");
   end

   // Storage register: clear wins over data, all bits load together.
   always_ff @(posedge CLOCK) begin
      if (CLEAR) begin
         OUTPUT <= RESET_VALUE;
      end else begin
         OUTPUT <= INPUT;
      end
   end

endmodule

// File: tb/tb_dff_asynch.sv
// tb_dff_asynch: directed scenarios plus randomized traffic for two instances
// (1-bit, reset 0) and (8-bit, reset 0xA5), checked against an edge-level model.
`timescale 1ns/1ps
module tb_dff_asynch;

   localparam logic [7:0] RV8 = 8'hA5;

   logic       clk = 1'b0;
   logic [0:0] d1;
   logic       clr1;
   logic [0:0] q1;
   logic [7:0] d8;
   logic       clr8;
   logic [7:0] q8;

   int total = 0;
   int bad   = 0;

   // Model state: value each register should hold after the most recent edge.
   logic [0:0] exp1;
   logic [7:0] exp8;

   // Period 20, first rising edge at t=10.
   always #10 clk = ~clk;

   dff_asynch #(.WIDTH(1), .RESET_VALUE(1'b0)) u_w1 (
      .INPUT (d1),
      .CLOCK (clk),
      .CLEAR (clr1),
      .OUTPUT(q1)
   );

   dff_asynch #(.WIDTH(8), .RESET_VALUE(RV8)) u_w8 (
      .INPUT (d8),
      .CLOCK (clk),
      .CLEAR (clr8),
      .OUTPUT(q8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference rule for one rising edge: clear loads the reset value, else data.
   function automatic logic [63:0] next_val(input logic clr, input logic [63:0] d,
                                            input logic [63:0] rv);
      return clr ? rv : d;
   endfunction

   // Advance to just after the next rising edge, updating the model first.
   task automatic edge_step();
      logic [0:0] n1;
      logic [7:0] n8;
      n1 = 1'(next_val(clr1, 64'(d1), 64'(1'b0)));
      n8 = 8'(next_val(clr8, 64'(d8), 64'(RV8)));
      @(posedge clk);
      exp1 = n1;
      exp8 = n8;
      #1;
   endtask

   initial begin
      // Load: INPUT=1 from t=0; wide instance starts in clear.
      d1 = 1'b1; clr1 = 1'b0;
      d8 = 8'h00; clr8 = 1'b1;
      edge_step();                                   // t=10 edge
      check("load_t10", 64'(q1), 64'(1'b1));
      check("wide_clear", 64'(q8), 64'(RV8));
      d8 = 8'h3C; clr8 = 1'b0;
      edge_step();                                   // t=30 edge
      check("load_t30", 64'(q1), 64'(1'b1));
      check("wide_load", 64'(q8), 64'h3C);

      // Mid-cycle changes on INPUT must not reach OUTPUT.
      d8 = 8'hFF; d1 = 1'b0;
      #3;
      check("wide_hold_mid", 64'(q8), 64'h3C);
      check("hold_mid", 64'(q1), 64'(1'b1));
      @(negedge clk); #1;
      check("wide_hold_negedge", 64'(q8), 64'h3C);
      check("hold_negedge", 64'(q1), 64'(1'b1));

      // Clear pulse strictly between edges is ignored.
      d1 = 1'b1; d8 = 8'h3C;
      @(posedge clk); exp1 = 1'b1; exp8 = 8'h3C;     // t=50 edge
      #2;  clr1 = 1'b1; clr8 = 1'b1;
      #6;  clr1 = 1'b0; clr8 = 1'b0;
      check("clr_glitch_mid", 64'(q1), 64'(1'b1));
      check("wide_clr_glitch_mid", 64'(q8), 64'h3C);
      edge_step();
      check("clr_glitch_after", 64'(q1), 64'(1'b1));
      check("wide_clr_glitch_after", 64'(q8), 64'h3C);

      // Clear priority over INPUT=1, then held clear with INPUT=0.
      clr1 = 1'b1; d1 = 1'b1;
      edge_step();
      check("clr_priority", 64'(q1), 64'(1'b0));
      d1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         edge_step();
         check("clr_held", 64'(q1), 64'(1'b0));
      end

      // Release with INPUT=0, then clear with INPUT=1, then release with INPUT=1.
      clr1 = 1'b0; d1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         edge_step();
         check("release_zero", 64'(q1), 64'(1'b0));
      end
      clr1 = 1'b1; d1 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         edge_step();
         check("clr_over_one", 64'(q1), 64'(1'b0));
      end
      clr1 = 1'b0;
      edge_step();
      check("release_first_edge", 64'(q1), 64'(1'b1));

      // Wide clear priority over data.
      clr8 = 1'b1; d8 = 8'h5A;
      edge_step();
      check("wide_clr_priority", 64'(q8), 64'(RV8));
      clr8 = 1'b0;
      edge_step();
      check("wide_release", 64'(q8), 64'h5A);

      // Randomized traffic with mid-cycle glitches on both INPUT and CLEAR.
      for (int i = 0; i < 300; i++) begin
         #2;
         d1   = 1'($urandom);
         clr1 = 1'($urandom);
         d8   = 8'($urandom);
         clr8 = 1'($urandom);
         @(negedge clk); #1;
         check("rand_negedge_w1", 64'(q1), 64'(exp1));
         check("rand_negedge_w8", 64'(q8), 64'(exp8));
         #2;
         d1   = 1'($urandom);
         clr1 = ($urandom_range(0, 3) == 0);
         d8   = 8'($urandom);
         clr8 = ($urandom_range(0, 3) == 0);
         edge_step();
         check("rand_edge_w1", 64'(q1), 64'(exp1));
         check("rand_edge_w8", 64'(q8), 64'(exp8));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
